uart_stream_rx: RTL and testbench

Parametrised UART receive core for the next-generation UART peripheral: oversampled start/data/stop detection with a built-in baud divider, a first-word-fall-through receive FIFO and a valid/ready output stream. It generalises the fixed 16550-style receive path in three ways: configurable character width, oversampling factor and FIFO depth. It sits between the pad-side `rxd` line (after loopback muxing) and the register/interrupt logic, which pops characters and monitors status.

---
 rtl/uart_stream_rx.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_uart_stream_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stream_rx.sv
// uart_stream_rx
//
// Oversampled UART receive core with a built-in baud divider, a
// first-word-fall-through receive FIFO and a valid/ready output stream.
// Each bit is sampled three times around its mid-point and decided by
// majority vote. Framing errors, breaks, overruns and a character-time
// idle timeout are reported.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Defined   : adds parity_odd_i, a parity bit in every frame and a parity
//               error flag stored with each character.
//   Undefined : frame is start + data + stop; parity_err_o is tied 0.
//
// Ports
//   clk_i         single clock
//   rst_i         synchronous active-high reset
//   div_i         clock cycles per oversample tick minus one
//   parity_odd_i  1 = odd parity, 0 = even (UART_RX_PARITY_EN only)
//   rxd_i         asynchronous serial input, idle high
//   data_o        FIFO head character (0 when empty)
//   frame_err_o   head character was received with stop bit 0
//   parity_err_o  head character had a parity mismatch
//   valid_o       FIFO not empty
//   ready_i       consumer pops the head when valid_o & ready_i
//   fill_o        current FIFO occupancy
//   overrun_o     one-cycle pulse when a character is dropped (FIFO full)
//   break_o       one-cycle pulse when a break is detected
//   timeout_o     level, FIFO idle for TimeoutChars character-times
module uart_stream_rx #(
  parameter int DataBits     = 8,
  parameter int Oversample   = 16,
  parameter int DivWidth     = 16,
  parameter int FifoDepth    = 16,
  parameter int TimeoutChars = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DivWidth-1:0]            div_i,
`ifdef UART_RX_PARITY_EN
  input  logic                           parity_odd_i,
`endif
  input  logic                           rxd_i,
  output logic [DataBits-1:0]            data_o,
  output logic                           frame_err_o,
  output logic                           parity_err_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [$clog2(FifoDepth+1)-1:0] fill_o,
  output logic                           overrun_o,
  output logic                           break_o,
  output logic                           timeout_o
);

`ifdef UART_RX_PARITY_EN
  localparam int ParBits = 1;
`else
  localparam int ParBits = 0;
`endif
  // FIFO entry: {frame_err, [parity_err], data}
  localparam int EntryW    = DataBits + 1 + ParBits;
  localparam int ScW       = $clog2(Oversample);
  localparam int BcW       = $clog2(DataBits);
  localparam int AddrW     = $clog2(FifoDepth);
  localparam int CharTicks = Oversample * (DataBits + 2 + ParBits);
  localparam int CtW       = $clog2(CharTicks);
  localparam int TcW       = $clog2(TimeoutChars + 1);

  localparam logic [ScW-1:0]      ScLast   = ScW'(Oversample - 1);
  // Samples at mid-1, mid, mid+1; the vote is taken on the mid+1 tick.
  localparam logic [ScW-1:0]      ScDecide = ScW'(Oversample / 2 + 1);
  localparam logic [ScW-1:0]      ScOne    = ScW'(1);
  localparam logic [BcW-1:0]      BcLast   = BcW'(DataBits - 1);
  localparam logic [BcW-1:0]      BcOne    = BcW'(1);
  localparam logic [AddrW:0]      PtrOne   = (AddrW+1)'(1);
  localparam logic [DivWidth-1:0] DivOne   = DivWidth'(1);
  localparam logic [CtW-1:0]      CtLast   = CtW'(CharTicks - 1);
  localparam logic [CtW-1:0]      CtOne    = CtW'(1);
  localparam logic [TcW-1:0]      TcLast   = TcW'(TimeoutChars - 1);
  localparam logic [TcW-1:0]      TcMax    = TcW'(TimeoutChars);
  localparam logic [TcW-1:0]      TcOne    = TcW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRKWAIT
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchroniser and edge detect
  logic meta, rxs, rxs_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta  <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      meta  <= rxd_i;
      rxs   <= meta;
      rxs_d <= rxs;
    end
  end

  // Oversample tick generator
  state_t              state, state_nx;
  logic                start_det;
  logic [DivWidth-1:0] tcnt;
  logic                tick;

  assign tick = (tcnt == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcnt <= '0;
    end else if (start_det || tick) begin
      tcnt <= div_i;
    end else begin
      tcnt <= tcnt - DivOne;
    end
  end

  // Bit sampling and receive FSM
  logic [ScW-1:0]      sc;
  logic [BcW-1:0]      bitcnt;
  logic                s0, s1;
  logic [DataBits-1:0] shreg;
  logic                decide;
  logic                bit_maj;
  logic                push;
  logic                brk;
  logic [EntryW-1:0]   entry;
`ifdef UART_RX_PARITY_EN
  logic                pbit;
  logic                perr;
`endif

  assign decide  = tick && (sc == ScDecide);
  assign bit_maj = maj3(s1, s0, rxs);

`ifdef UART_RX_PARITY_EN
  assign entry = {~bit_maj, perr, shreg};
`else
  assign entry = {~bit_maj, shreg};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      sc     <= '0;
      bitcnt <= '0;
    end else begin
      state <= state_nx;
      if (start_det) begin
        sc <= '0;
      end else if (tick) begin
        sc <= (sc == ScLast) ? '0 : sc + ScOne;
      end
      if (decide && state == START) begin
        bitcnt <= '0;
      end else if (decide && state == DATA) begin
        bitcnt <= bitcnt + BcOne;
      end
    end
  end

  // Sample history and character assembly carry no reset; they are always
  // rewritten before use within a frame.
  always_ff @(posedge clk_i) begin
    if (tick) begin
      s1 <= s0;
      s0 <= rxs;
    end
    if (decide && state == DATA) begin
      shreg <= {bit_maj, shreg[DataBits-1:1]};
    end
`ifdef UART_RX_PARITY_EN
    if (decide && state == PARITY) begin
      pbit <= bit_maj;
      perr <= (^shreg) ^ bit_maj ^ parity_odd_i;
    end
`endif
  end

  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    push      = 1'b0;
    brk       = 1'b0;
    case (state)
      IDLE: begin
        if (rxs_d && !rxs) begin
          start_det = 1'b1;
          state_nx  = START;
        end
      end
      START: begin
        if (decide) begin
          state_nx = bit_maj ? IDLE : DATA;
        end
      end
      DATA: begin
        if (decide && bitcnt == BcLast) begin
`ifdef UART_RX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide) begin
          state_nx = STOP;
        end
      end
`endif
      STOP: begin
        if (decide) begin
`ifdef UART_RX_PARITY_EN
          if (!bit_maj && shreg == '0 && !pbit) begin
`else
          if (!bit_maj && shreg == '0) begin
`endif
            brk      = 1'b1;
            state_nx = BRKWAIT;
          end else begin
            push     = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      BRKWAIT: begin
        if (rxs) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Receive FIFO (first-word fall-through)
  logic [EntryW-1:0] mem [FifoDepth];
  logic [AddrW:0]    wptr, rptr;
  logic              empty, full, pop, wr;
  logic [EntryW-1:0] head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AddrW] != rptr[AddrW]) &&
                 (wptr[AddrW-1:0] == rptr[AddrW-1:0]);
  assign pop   = ready_i && !empty;
  // When full, a simultaneous pop frees the slot being written.
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr      <= '0;
      rptr      <= '0;
      overrun_o <= 1'b0;
      break_o   <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + PtrOne;
      end
      if (pop) begin
        rptr <= rptr + PtrOne;
      end
      overrun_o <= push && full && !pop;
      break_o   <= brk;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem[wptr[AddrW-1:0]] <= entry;
    end
  end

  // Head is masked while empty so the outputs read 0 out of reset.
  assign head        = mem[rptr[AddrW-1:0]];
  assign valid_o     = !empty;
  assign data_o      = empty ? '0 : head[DataBits-1:0];
  assign frame_err_o = !empty && head[EntryW-1];
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = !empty && head[DataBits];
`else
  assign parity_err_o = 1'b0;
`endif
  assign fill_o      = wptr - rptr;

  // Character-time idle timeout
  logic [CtW-1:0] to_ticks;
  logic [TcW-1:0] to_chars;
  logic           to_clr, to_run;

  assign to_clr = pop || start_det || empty;
  assign to_run = !empty && (state == IDLE) && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_ticks  <= '0;
      to_chars  <= '0;
      timeout_o <= 1'b0;
    end else if (to_clr) begin
      to_ticks  <= '0;
      to_chars  <= '0;
      timeout_o <= 1'b0;
    end else if (to_run && tick) begin
      if (to_ticks == CtLast) begin
        to_ticks <= '0;
        if (to_chars != TcMax) begin
          to_chars <= to_chars + TcOne;
        end
        if (to_chars == TcLast) begin
          timeout_o <= 1'b1;
        end
      end else begin
        to_ticks <= to_ticks + CtOne;
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_rx.sv
module tb_uart_stream_rx;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int FD = 4;
  localparam int TC = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int CHAR = OS * (DB + 2 + PB);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div = 16'd0;
  logic        rxd = 1'b1;
  logic        ready = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic        parity_odd = 1'b0;
`endif
  logic [DB-1:0] data;
  logic          frame_err, parity_err, valid, overrun, brk_p, timeout;
  logic [2:0]    fill;

  int vecs = 0;
  int errs = 0;
  int brk_cnt = 0;
  int ovr_cnt = 0;

  uart_stream_rx #(
    .DataBits(DB), .Oversample(OS), .DivWidth(16), .FifoDepth(FD), .TimeoutChars(TC)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .div_i(div),
`ifdef UART_RX_PARITY_EN
    .parity_odd_i(parity_odd),
`endif
    .rxd_i(rxd),
    .data_o(data),
    .frame_err_o(frame_err),
    .parity_err_o(parity_err),
    .valid_o(valid),
    .ready_i(ready),
    .fill_o(fill),
    .overrun_o(overrun),
    .break_o(brk_p),
    .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (brk_p) brk_cnt = brk_cnt + 1;
    if (overrun) ovr_cnt = ovr_cnt + 1;
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    tick_n(OS);
  endtask

  // Stop-bit vote lands on the cycle after the 12th edge of the stop bit;
  // pop_at_push raises ready exactly for that cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input logic pop_at_push);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PB == 1) drive_bit(par);
    rxd = stop;
    tick_n(12);
    if (pop_at_push) ready = 1'b1;
    tick_n(1);
    ready = 1'b0;
    tick_n(3);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    tick_n(1);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxd = 1'b1;
    tick_n(3);
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b want=0", valid); end
    vecs++; if (fill !== 3'd0) begin errs++; $display("FAIL reset_fill got=%0d want=0", fill); end
    vecs++; if (data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h want=00", data); end
    vecs++; if ({frame_err, parity_err, overrun, brk_p, timeout} !== 5'b0) begin
      errs++; $display("FAIL reset_flags got=%b want=00000", {frame_err, parity_err, overrun, brk_p, timeout});
    end
    rst = 1'b0;
    tick_n(2);
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PB == 1) drive_bit(^d);
    rxd = 1'b1;
    tick_n(12);
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid got=%b want=0", valid); end
    tick_n(1);
    vecs++; if (valid !== 1'b1) begin errs++; $display("FAIL basic_valid got=%b want=1", valid); end
    vecs++; if (data !== 8'hA5) begin errs++; $display("FAIL basic_data got=%h want=a5", data); end
    vecs++; if ({frame_err, parity_err} !== 2'b00) begin errs++; $display("FAIL basic_errs got=%b want=00", {frame_err, parity_err}); end
    vecs++; if (fill !== 3'd1) begin errs++; $display("FAIL basic_fill got=%0d want=1", fill); end
    tick_n(3);
    pop_one();
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL basic_pop_valid got=%b want=0", valid); end
  endtask

  task automatic test_false_start();
    int b0, o0;
    b0 = brk_cnt; o0 = ovr_cnt;
    rxd = 1'b0;
    tick_n(5);
    rxd = 1'b1;
    tick_n(40);
    vecs++; if (fill !== 3'd0) begin errs++; $display("FAIL false_fill got=%0d want=0", fill); end
    vecs++; if (brk_cnt !== b0 || ovr_cnt !== o0) begin
      errs++; $display("FAIL false_pulses got=%0d/%0d want=0/0", brk_cnt - b0, ovr_cnt - o0);
    end
    send_frame(8'h81, 1'b1, ^8'h81, 1'b0);
    vecs++; if (data !== 8'h81 || valid !== 1'b1) begin errs++; $display("FAIL false_recover got=%h/%b want=81/1", data, valid); end
    pop_one();
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    rxd = 1'b1;
    tick_n(16);
    vecs++; if (data !== 8'h3C) begin errs++; $display("FAIL frame_data got=%h want=3c", data); end
    vecs++; if (frame_err !== 1'b1) begin errs++; $display("FAIL frame_err got=%b want=1", frame_err); end
    vecs++; if (parity_err !== 1'b0) begin errs++; $display("FAIL frame_perr got=%b want=0", parity_err); end
    pop_one();
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL frame_pop got=%b want=0", valid); end
  endtask

  task automatic test_break();
    int b0;
    b0 = brk_cnt;
    rxd = 1'b0;
    tick_n(2 * CHAR);
    vecs++; if (brk_cnt - b0 !== 1) begin errs++; $display("FAIL break_pulses got=%0d want=1", brk_cnt - b0); end
    vecs++; if (fill !== 3'd0) begin errs++; $display("FAIL break_fill got=%0d want=0", fill); end
    rxd = 1'b1;
    tick_n(32);
    send_frame(8'h55, 1'b1, ^8'h55, 1'b0);
    vecs++; if (data !== 8'h55 || frame_err !== 1'b0) begin errs++; $display("FAIL break_next got=%h/%b want=55/0", data, frame_err); end
    vecs++; if (fill !== 3'd1) begin errs++; $display("FAIL break_next_fill got=%0d want=1", fill); end
    vecs++; if (brk_cnt - b0 !== 1) begin errs++; $display("FAIL break_once got=%0d want=1", brk_cnt - b0); end
    pop_one();
  endtask

  task automatic test_overrun();
    int o0;
    logic [7:0] d;
    o0 = ovr_cnt;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      send_frame(d, 1'b1, ^d, 1'b0);
    end
    vecs++; if (fill !== 3'd4 || ovr_cnt !== o0) begin errs++; $display("FAIL ovr_full got=%0d/%0d want=4/0", fill, ovr_cnt - o0); end
    send_frame(8'h05, 1'b1, ^8'h05, 1'b0);
    vecs++; if (ovr_cnt - o0 !== 1) begin errs++; $display("FAIL ovr_pulse got=%0d want=1", ovr_cnt - o0); end
    vecs++; if (fill !== 3'd4) begin errs++; $display("FAIL ovr_fill got=%0d want=4", fill); end
    for (int i = 1; i <= 4; i++) begin
      vecs++; if (data !== 8'(i)) begin errs++; $display("FAIL ovr_drain got=%h want=%h", data, 8'(i)); end
      pop_one();
    end
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL ovr_empty got=%b want=0", valid); end
  endtask

  task automatic test_overrun_pop();
    int o0;
    logic [7:0] d;
    o0 = ovr_cnt;
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i);
      send_frame(d, 1'b1, ^d, 1'b0);
    end
    send_frame(8'h05, 1'b1, ^8'h05, 1'b1);
    vecs++; if (ovr_cnt !== o0) begin errs++; $display("FAIL ovpop_pulse got=%0d want=0", ovr_cnt - o0); end
    vecs++; if (fill !== 3'd4) begin errs++; $display("FAIL ovpop_fill got=%0d want=4", fill); end
    for (int i = 2; i <= 5; i++) begin
      vecs++; if (data !== 8'(i)) begin errs++; $display("FAIL ovpop_drain got=%h want=%h", data, 8'(i)); end
      pop_one();
    end
    vecs++; if (valid !== 1'b0) begin errs++; $display("FAIL ovpop_empty got=%b want=0", valid); end
  endtask

  task automatic test_mid_reset();
    int b0, o0;
    b0 = brk_cnt; o0 = ovr_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b1;
    rxd = 1'b1;
    tick_n(1);
    rst = 1'b0;
    tick_n(2 * CHAR);
    vecs++; if (fill !== 3'd0 || valid !== 1'b0) begin errs++; $display("FAIL midrst_fill got=%0d/%b want=0/0", fill, valid); end
    vecs++; if (brk_cnt !== b0 || ovr_cnt !== o0) begin errs++; $display("FAIL midrst_pulses got=%0d/%0d want=0/0", brk_cnt - b0, ovr_cnt - o0); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    vecs++; if (data !== 8'h07 || parity_err !== 1'b1) begin errs++; $display("FAIL par_bad got=%h/%b want=07/1", data, parity_err); end
    pop_one();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    vecs++; if (data !== 8'h07 || parity_err !== 1'b0) begin errs++; $display("FAIL par_good got=%h/%b want=07/0", data, parity_err); end
    pop_one();
  endtask
`endif

  task automatic test_timeout();
    send_frame(8'h42, 1'b1, ^8'h42, 1'b0);
    vecs++; if (data !== 8'h42) begin errs++; $display("FAIL to_data got=%h want=42", data); end
    tick_n(4 * CHAR - 40);
    vecs++; if (timeout !== 1'b0) begin errs++; $display("FAIL to_early got=%b want=0", timeout); end
    tick_n(40);
    vecs++; if (timeout !== 1'b1) begin errs++; $display("FAIL to_set got=%b want=1", timeout); end
    pop_one();
    vecs++; if (timeout !== 1'b0 || valid !== 1'b0) begin errs++; $display("FAIL to_clear got=%b/%b want=0/0", timeout, valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_framing();
    test_break();
    test_overrun();
    test_overrun_pop();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
